// File: rtl/vec_regfile_seq_if.sv
// Port bundle for vec_regfile_seq: three LMUL-grouped read ports, the group-write
// handshake, the v0 mask write and status flags. master = requester, slave = register file.
interface vec_regfile_seq_if #(
  parameter int VLEN       = 128,
  parameter int MAX_LMUL   = 8,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0]    raddr_1, raddr_2, raddr_3;
  logic [3:0]               rd_lmul;
  logic [MAX_LMUL*VLEN-1:0] rdata_1, rdata_2, rdata_3;
  logic                     rd_err_1, rd_err_2, rd_err_3;
  logic                     rd_hazard_1, rd_hazard_2, rd_hazard_3;
  logic                     wr_valid;
  logic                     wr_ready;
  logic [ADDR_WIDTH-1:0]    waddr;
  logic [3:0]               wr_lmul;
  logic [MAX_LMUL*VLEN-1:0] wdata;
  logic                     mask_wr_en;
  logic                     err_clr;
  logic                     busy;
  logic                     data_written;
  logic                     wrong_addr;
  logic [VLEN-1:0]          v0_mask_data;

  modport master (
    output raddr_1, raddr_2, raddr_3, rd_lmul,
    output wr_valid, waddr, wr_lmul, wdata, mask_wr_en, err_clr,
    input  rdata_1, rdata_2, rdata_3, rd_err_1, rd_err_2, rd_err_3,
    input  rd_hazard_1, rd_hazard_2, rd_hazard_3,
    input  wr_ready, busy, data_written, wrong_addr, v0_mask_data
  );

  modport slave (
    input  raddr_1, raddr_2, raddr_3, rd_lmul,
    input  wr_valid, waddr, wr_lmul, wdata, mask_wr_en, err_clr,
    output rdata_1, rdata_2, rdata_3, rd_err_1, rd_err_2, rd_err_3,
    output rd_hazard_1, rd_hazard_2, rd_hazard_3,
    output wr_ready, busy, data_written, wrong_addr, v0_mask_data
  );
endinterface

// File: rtl/vec_regfile_seq.sv
// NUM_REGS x VLEN vector register file: three combinational LMUL-grouped read ports,
// a sequenced group-write engine with pending-write scoreboard, and a protected v0.
module vec_regfile_seq #(
  parameter int VLEN            = 128,
  parameter int NUM_REGS        = 32,
  parameter int MAX_LMUL        = 8,
  parameter int WR_REGS_PER_CYC = 1,
  parameter int ADDR_WIDTH      = $clog2(NUM_REGS)
) (
  input logic              clk,
  input logic              reset,
  vec_regfile_seq_if.slave rf
);
  localparam int W      = WR_REGS_PER_CYC;
  localparam int BEAT_W = $clog2(MAX_LMUL) + 1;
  localparam int GW     = MAX_LMUL * VLEN;

  typedef enum logic {IDLE, WRITE} state_t;

  function automatic logic group_legal(input logic [ADDR_WIDTH-1:0] base,
                                       input logic [3:0]            lmul);
    int n;
    n = int'(lmul);
    return $onehot(lmul) && (n <= MAX_LMUL) && ((int'(base) & (n - 1)) == 0)
           && ((int'(base) + n) <= NUM_REGS);
  endfunction

  function automatic logic [NUM_REGS-1:0] group_mask(input logic [ADDR_WIDTH-1:0] base,
                                                     input logic [3:0]            lmul);
    logic [NUM_REGS-1:0] m;
    m = '0;
    for (int r = 0; r < NUM_REGS; r++)
      m[r] = (r >= int'(base)) && (r < int'(base) + int'(lmul));
    return m;
  endfunction

  logic [VLEN-1:0]       regs [NUM_REGS];
  logic [NUM_REGS-1:0]   pending;
  state_t                state, state_nxt;
  logic [BEAT_W-1:0]     beat;
  logic [ADDR_WIDTH-1:0] wr_base;
  logic [3:0]            wr_lmul_q;
  logic [GW-1:0]         wr_buf;
  logic                  data_written_q;
  logic                  wrong_addr_q;

  logic                  accept;
  logic                  accept_legal;
  logic                  last_beat;
  logic [W-1:0]          slot_en;
  logic [ADDR_WIDTH-1:0] slot_idx  [W];
  logic [VLEN-1:0]       slot_data [W];

  logic [ADDR_WIDTH-1:0] raddr     [3];
  logic [GW-1:0]         rdata     [3];
  logic [2:0]            rd_err;
  logic [2:0]            rd_hazard;

  assign accept       = rf.wr_valid && (state == IDLE);
  assign accept_legal = accept && group_legal(rf.waddr, rf.wr_lmul);
  assign last_beat    = ((int'(beat) + 1) * W) >= int'(wr_lmul_q);

  // ---------------- read ports ----------------
  assign raddr[0] = rf.raddr_1;
  assign raddr[1] = rf.raddr_2;
  assign raddr[2] = rf.raddr_3;

  // NOTE: every output of a combinational block gets a default first, so no path
  // through the ifs leaves a variable unassigned and infers a latch.
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rd_err[p]    = !group_legal(raddr[p], rf.rd_lmul);
      rdata[p]     = '0;
      rd_hazard[p] = 1'b0;
      if (!rd_err[p]) begin
        for (int i = 0; i < MAX_LMUL; i++)
          if (i < int'(rf.rd_lmul))
            rdata[p][i*VLEN +: VLEN] = regs[ADDR_WIDTH'(int'(raddr[p]) + i)];
        rd_hazard[p] = |(pending & group_mask(raddr[p], rf.rd_lmul));
      end
    end
  end

  assign rf.rdata_1     = rdata[0];
  assign rf.rdata_2     = rdata[1];
  assign rf.rdata_3     = rdata[2];
  assign rf.rd_err_1    = rd_err[0];
  assign rf.rd_err_2    = rd_err[1];
  assign rf.rd_err_3    = rd_err[2];
  assign rf.rd_hazard_1 = rd_hazard[0];
  assign rf.rd_hazard_2 = rd_hazard[1];
  assign rf.rd_hazard_3 = rd_hazard[2];

  // ---------------- write engine ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_legal) state_nxt = WRITE;
      WRITE:   if (last_beat)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registers committed on this beat; slots past the group end and the v0 slot are dropped.
  always_comb begin
    for (int j = 0; j < W; j++) begin
      slot_idx[j]  = wr_base + ADDR_WIDTH'(int'(beat) * W + j);
      slot_data[j] = wr_buf[((int'(beat) * W + j) % MAX_LMUL) * VLEN +: VLEN];
      slot_en[j]   = (state == WRITE) && ((int'(beat) * W + j) < int'(wr_lmul_q))
                     && (slot_idx[j] != '0);
    end
  end

  // NOTE: the array sits in the async reset because its contents must read 0 after
  // reset; that rules out a RAM macro and keeps the storage in flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      beat           <= '0;
      wr_base        <= '0;
      wr_lmul_q      <= '0;
      wr_buf         <= '0;
      pending        <= '0;
      data_written_q <= 1'b0;
      wrong_addr_q   <= 1'b0;
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else begin
      state          <= state_nxt;
      data_written_q <= (state == WRITE) && last_beat;

      if (accept && !accept_legal) wrong_addr_q <= 1'b1;
      else if (rf.err_clr)         wrong_addr_q <= 1'b0;

      if (accept_legal) begin
        wr_base   <= rf.waddr;
        wr_lmul_q <= rf.wr_lmul;
        wr_buf    <= rf.wdata;
        beat      <= '0;
        pending   <= pending | (group_mask(rf.waddr, rf.wr_lmul) & {{(NUM_REGS-1){1'b1}}, 1'b0});
      end else if (state == WRITE) begin
        beat <= beat + 1'b1;
        for (int j = 0; j < W; j++) begin
          if (slot_en[j]) begin
            regs[slot_idx[j]]    <= slot_data[j];
            pending[slot_idx[j]] <= 1'b0;
          end
        end
      end

      // Group writes never target v0, so this cannot collide with a commit slot.
      if (rf.mask_wr_en) regs[0] <= rf.wdata[VLEN-1:0];
    end
  end

  assign rf.wr_ready     = (state == IDLE);
  assign rf.busy         = (state == WRITE);
  assign rf.data_written = data_written_q;
  assign rf.wrong_addr   = wrong_addr_q;
  assign rf.v0_mask_data = regs[0];
endmodule

// File: tb/tb_vec_regfile_seq.sv
// Self-checking bench for vec_regfile_seq: directed corner sequences, a read-legality
// vector table, and randomized traffic scored against a commit-schedule model.
module tb_vec_regfile_seq;
  localparam int VLEN     = 128;
  localparam int NUM_REGS = 32;
  localparam int MAX_LMUL = 8;
  localparam int W        = 1;
  localparam int AW       = 5;
  localparam int GW       = MAX_LMUL * VLEN;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vec_regfile_seq_if #(.VLEN(VLEN), .MAX_LMUL(MAX_LMUL), .ADDR_WIDTH(AW)) rf ();

  vec_regfile_seq #(
    .VLEN(VLEN), .NUM_REGS(NUM_REGS), .MAX_LMUL(MAX_LMUL),
    .WR_REGS_PER_CYC(W), .ADDR_WIDTH(AW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .rf   (rf)
  );

  // ---------------- reference model ----------------
  // A group write is a list of scheduled register commits, each due at a known edge.
  typedef struct {
    int              r;
    logic [VLEN-1:0] d;
    int              due;
  } wr_item_t;

  logic [VLEN-1:0] m_regs [NUM_REGS];
  wr_item_t        m_q [$];
  int              m_edge       = 0;
  int              m_busy_until = 0;
  bit              m_dw         = 0;
  bit              m_werr       = 0;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic bit m_legal(input int base, input int n);
    return (n == 1 || n == 2 || n == 4 || n == 8) && (n <= MAX_LMUL)
           && (base % n == 0) && (base + n <= NUM_REGS);
  endfunction

  function automatic logic [GW-1:0] m_read(input int base, input int n);
    logic [GW-1:0] r;
    r = '0;
    if (m_legal(base, n))
      for (int k = 0; k < n; k++) r[k*VLEN +: VLEN] = m_regs[base + k];
    return r;
  endfunction

  function automatic bit m_hazard(input int base, input int n);
    if (!m_legal(base, n)) return 1'b0;
    foreach (m_q[i]) if (m_q[i].r >= base && m_q[i].r < base + n) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NUM_REGS; r++) m_regs[r] = '0;
    m_q.delete();
    m_busy_until = 0;
    m_dw         = 0;
    m_werr       = 0;
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_edge();
    wr_item_t keep [$];
    bit       was_busy;
    bit       acc;
    int       n;
    int       base;
    was_busy = (m_edge < m_busy_until);
    acc      = rf.wr_valid && !was_busy;
    m_dw     = was_busy && (m_edge + 1 == m_busy_until);
    foreach (m_q[i]) begin
      if (m_q[i].due == m_edge + 1) m_regs[m_q[i].r] = m_q[i].d;
      else keep.push_back(m_q[i]);
    end
    m_q = keep;
    if (rf.mask_wr_en) m_regs[0] = rf.wdata[VLEN-1:0];
    n    = int'(rf.wr_lmul);
    base = int'(rf.waddr);
    if (acc && m_legal(base, n)) begin
      for (int k = 0; k < n; k++)
        if (base + k != 0)
          m_q.push_back('{r: base + k, d: rf.wdata[k*VLEN +: VLEN], due: m_edge + 2 + k / W});
      m_busy_until = m_edge + 1 + ((n / W > 1) ? n / W : 1);
    end
    if (acc && !m_legal(base, n)) m_werr = 1;
    else if (rf.err_clr)          m_werr = 0;
    m_edge++;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string nm, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_wide(input string nm, input logic [GW-1:0] act, input logic [GW-1:0] exp);
    int bad;
    bad = -1;
    n_checks++;
    for (int k = MAX_LMUL - 1; k >= 0; k--)
      if (act[k*VLEN +: VLEN] !== exp[k*VLEN +: VLEN]) bad = k;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s word %0d: got %0h expected %0h (t=%0t)", nm, bad,
               act[bad*VLEN +: VLEN], exp[bad*VLEN +: VLEN], $time);
    end
  endtask

  task automatic check_port(input string nm, input logic [AW-1:0] a, input logic [GW-1:0] d,
                            input logic e, input logic h);
    int base;
    int n;
    base = int'(a);
    n    = int'(rf.rd_lmul);
    check({nm, "_err"}, VLEN'(e), VLEN'(!m_legal(base, n)));
    check_wide({nm, "_rdata"}, d, m_read(base, n));
    check({nm, "_hazard"}, VLEN'(h), VLEN'(m_hazard(base, n)));
  endtask

  task automatic compare_all();
    #1;
    check("wr_ready", VLEN'(rf.wr_ready), VLEN'(m_edge >= m_busy_until));
    check("busy", VLEN'(rf.busy), VLEN'(m_edge < m_busy_until));
    check("data_written", VLEN'(rf.data_written), VLEN'(m_dw));
    check("wrong_addr", VLEN'(rf.wrong_addr), VLEN'(m_werr));
    check("v0_mask_data", rf.v0_mask_data, m_regs[0]);
    check_port("p1", rf.raddr_1, rf.rdata_1, rf.rd_err_1, rf.rd_hazard_1);
    check_port("p2", rf.raddr_2, rf.rdata_2, rf.rd_err_2, rf.rd_hazard_2);
    check_port("p3", rf.raddr_3, rf.rdata_3, rf.rd_err_3, rf.rd_hazard_3);
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    rf.wr_valid   = 1'b0;
    rf.mask_wr_en = 1'b0;
    rf.err_clr    = 1'b0;
    rf.waddr      = '0;
    rf.wr_lmul    = 4'b0001;
    rf.wdata      = '0;
    rf.raddr_1    = '0;
    rf.raddr_2    = '0;
    rf.raddr_3    = '0;
    rf.rd_lmul    = 4'b0001;
  endtask

  function automatic logic [VLEN-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- read legality vector table ----------------
  typedef struct {
    logic [AW-1:0]   addr;
    logic [3:0]      lmul;
    logic            exp_err;
    logic [VLEN-1:0] exp_w0;
  } rd_vec_t;

  rd_vec_t tbl [14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [GW-1:0]   exp_w;
    logic [GW-1:0]   saved;
    logic [VLEN-1:0] ones;
    int              nsel;

    // Table runs after the first directed write leaves v8..v11 = 1..4.
    tbl[0]  = '{5'd8,  4'b0100, 1'b0, 128'h1};
    tbl[1]  = '{5'd10, 4'b0001, 1'b0, 128'h3};
    tbl[2]  = '{5'd10, 4'b0010, 1'b0, 128'h3};
    tbl[3]  = '{5'd9,  4'b0001, 1'b0, 128'h2};
    tbl[4]  = '{5'd6,  4'b0100, 1'b1, 128'h0};
    tbl[5]  = '{5'd11, 4'b0001, 1'b0, 128'h4};
    tbl[6]  = '{5'd28, 4'b1000, 1'b1, 128'h0};
    tbl[7]  = '{5'd24, 4'b1000, 1'b0, 128'h0};
    tbl[8]  = '{5'd31, 4'b0010, 1'b1, 128'h0};
    tbl[9]  = '{5'd0,  4'b0011, 1'b1, 128'h0};
    tbl[10] = '{5'd0,  4'b0000, 1'b1, 128'h0};
    tbl[11] = '{5'd8,  4'b1100, 1'b1, 128'h0};
    tbl[12] = '{5'd30, 4'b0010, 1'b0, 128'h0};
    tbl[13] = '{5'd8,  4'b1000, 1'b0, 128'h1};

    ones = '1;
    reset = 1'b0;
    set_idle();
    model_reset();
    compare_all();
    check("rst_wr_ready", VLEN'(rf.wr_ready), VLEN'(1));
    check("rst_busy", VLEN'(rf.busy), VLEN'(0));
    #10 reset = 1'b1;

    // A: 4-register group at v8, one register per beat, read of v10 watching the hazard.
    rf.waddr    = 5'd8;
    rf.wr_lmul  = 4'b0100;
    for (int k = 0; k < 4; k++) rf.wdata[k*VLEN +: VLEN] = VLEN'(k + 1);
    rf.wr_valid = 1'b1;
    rf.raddr_1  = 5'd10;
    rf.rd_lmul  = 4'b0001;
    cycle();
    rf.wr_valid = 1'b0;
    for (int s = 0; s <= 5; s++) begin
      if (s > 0) cycle();
      compare_all();
      check("A_wr_ready", VLEN'(rf.wr_ready), VLEN'(s >= 4));
      check("A_hazard", VLEN'(rf.rd_hazard_1), VLEN'(s < 3));
      check("A_rdata", rf.rdata_1[VLEN-1:0], (s >= 3) ? VLEN'(3) : VLEN'(0));
      check("A_dw", VLEN'(rf.data_written), VLEN'(s == 4));
    end
    rf.rd_lmul = 4'b0100;
    rf.raddr_1 = 5'd8;
    exp_w = '0;
    for (int k = 0; k < 4; k++) exp_w[k*VLEN +: VLEN] = VLEN'(k + 1);
    #1 check_wide("A_group", rf.rdata_1, exp_w);

    for (int i = 0; i < 14; i++) begin
      rf.raddr_1 = tbl[i].addr;
      rf.raddr_2 = tbl[i].addr;
      rf.rd_lmul = tbl[i].lmul;
      #1;
      check("T_err_1", VLEN'(rf.rd_err_1), VLEN'(tbl[i].exp_err));
      check("T_err_2", VLEN'(rf.rd_err_2), VLEN'(tbl[i].exp_err));
      check("T_w0", rf.rdata_1[VLEN-1:0], tbl[i].exp_w0);
      check("T_hazard", VLEN'(rf.rd_hazard_1), VLEN'(0));
    end

    // B: group write covering v0 must leave v0 alone.
    set_idle();
    rf.mask_wr_en = 1'b1;
    rf.wdata      = GW'(128'hA5);
    cycle();
    rf.mask_wr_en = 1'b0;
    compare_all();
    check("B_v0_pre", rf.v0_mask_data, 128'hA5);
    rf.wdata    = '1;
    rf.waddr    = 5'd0;
    rf.wr_lmul  = 4'b0010;
    rf.wr_valid = 1'b1;
    cycle();
    rf.wr_valid = 1'b0;
    rf.raddr_2  = 5'd0;
    rf.raddr_3  = 5'd1;
    compare_all();
    check("B_v0_hazard", VLEN'(rf.rd_hazard_2), VLEN'(0));
    check("B_v1_hazard", VLEN'(rf.rd_hazard_3), VLEN'(1));
    cycle();
    compare_all();
    check("B_dw_early", VLEN'(rf.data_written), VLEN'(0));
    cycle();
    compare_all();
    check("B_dw", VLEN'(rf.data_written), VLEN'(1));
    check("B_v0", rf.v0_mask_data, 128'hA5);
    check("B_v1", rf.rdata_3[VLEN-1:0], ones);

    // C: mask write during beat 1 of an 8-register group write at v8.
    set_idle();
    for (int k = 0; k < MAX_LMUL; k++) rf.wdata[k*VLEN +: VLEN] = rand_word();
    saved       = rf.wdata;
    rf.waddr    = 5'd8;
    rf.wr_lmul  = 4'b1000;
    rf.wr_valid = 1'b1;
    cycle();
    rf.wr_valid = 1'b0;
    compare_all();
    for (int s = 1; s <= 8; s++) begin
      if (s == 2) begin
        rf.mask_wr_en = 1'b1;
        rf.wdata      = GW'(128'hF0F0);
      end
      cycle();
      rf.mask_wr_en = 1'b0;
      compare_all();
      if (s == 2) check("C_v0", rf.v0_mask_data, 128'hF0F0);
      check("C_dw", VLEN'(rf.data_written), VLEN'(s == 8));
      check("C_busy", VLEN'(rf.busy), VLEN'(s < 8));
    end
    rf.raddr_1 = 5'd8;
    rf.rd_lmul = 4'b1000;
    #1 check_wide("C_group", rf.rdata_1, saved);

    // D: misaligned group -> sticky wrong_addr; error beats a same-edge clear.
    set_idle();
    rf.raddr_1  = 5'd4;
    rf.rd_lmul  = 4'b0100;
    rf.waddr    = 5'd6;
    rf.wr_lmul  = 4'b0100;
    rf.wdata    = '1;
    rf.wr_valid = 1'b1;
    cycle();
    rf.wr_valid = 1'b0;
    compare_all();
    check("D_werr", VLEN'(rf.wrong_addr), VLEN'(1));
    check("D_ready", VLEN'(rf.wr_ready), VLEN'(1));
    check_wide("D_untouched", rf.rdata_1, '0);
    cycle();
    cycle();
    compare_all();
    check("D_werr_held", VLEN'(rf.wrong_addr), VLEN'(1));
    rf.err_clr = 1'b1;
    cycle();
    rf.err_clr = 1'b0;
    compare_all();
    check("D_werr_clr", VLEN'(rf.wrong_addr), VLEN'(0));
    rf.err_clr  = 1'b1;
    rf.wr_valid = 1'b1;
    cycle();
    rf.wr_valid = 1'b0;
    compare_all();
    check("D_err_wins", VLEN'(rf.wrong_addr), VLEN'(1));
    cycle();
    rf.err_clr = 1'b0;
    compare_all();
    check("D_werr_clr2", VLEN'(rf.wrong_addr), VLEN'(0));

    // E: reset during beat 2 of an 8-register write at v16.
    set_idle();
    for (int k = 0; k < MAX_LMUL; k++) rf.wdata[k*VLEN +: VLEN] = rand_word();
    rf.waddr    = 5'd16;
    rf.wr_lmul  = 4'b1000;
    rf.wr_valid = 1'b1;
    cycle();
    rf.wr_valid = 1'b0;
    cycle();
    cycle();
    rf.raddr_1 = 5'd16;
    rf.rd_lmul = 4'b1000;
    compare_all();
    check("E_hazard_pre", VLEN'(rf.rd_hazard_1), VLEN'(1));
    reset = 1'b0;
    model_reset();
    rf.raddr_1 = 5'd0;
    rf.raddr_2 = 5'd8;
    rf.raddr_3 = 5'd16;
    compare_all();
    check("E_busy", VLEN'(rf.busy), VLEN'(0));
    check("E_ready", VLEN'(rf.wr_ready), VLEN'(1));
    check("E_hz3", VLEN'(rf.rd_hazard_3), VLEN'(0));
    check_wide("E_v16", rf.rdata_3, '0);
    check_wide("E_v8", rf.rdata_2, '0);
    rf.raddr_1 = 5'd24;
    #1 check_wide("E_v24", rf.rdata_1, '0);
    #1 reset = 1'b1;
    for (int s = 0; s < 10; s++) begin
      cycle();
      compare_all();
      check("E_no_dw", VLEN'(rf.data_written), VLEN'(0));
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      rf.wr_valid = ($urandom_range(0, 2) != 0);
      nsel = $urandom_range(0, 9);
      if (nsel < 8) rf.wr_lmul = 4'(1 << (nsel % 4));
      else          rf.wr_lmul = 4'($urandom);
      rf.waddr = AW'($urandom);
      if (nsel < 8 && $urandom_range(0, 4) != 0)
        rf.waddr = rf.waddr & ~(AW'(rf.wr_lmul) - AW'(1));
      for (int k = 0; k < MAX_LMUL; k++) rf.wdata[k*VLEN +: VLEN] = rand_word();
      rf.mask_wr_en = ($urandom_range(0, 5) == 0);
      rf.err_clr    = ($urandom_range(0, 7) == 0);
      rf.rd_lmul    = ($urandom_range(0, 9) < 9) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
      rf.raddr_1    = AW'($urandom) & ~(AW'(rf.rd_lmul) - AW'(1));
      rf.raddr_2    = AW'($urandom);
      rf.raddr_3    = AW'($urandom);
      cycle();
      compare_all();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vec_regfile_seq.md
Name: vec_regfile_seq

Overview:
Parametrised successor of the vector register file: NUM_REGS x VLEN storage with three combinational LMUL-grouped read ports and a sequenced group-write engine.
- The write engine accepts a whole LMUL group through a valid/ready handshake and commits WR_REGS_PER_CYC registers per cycle.
- A pending-write scoreboard flags read hazards.
- v0 is protected from group writes and updated only through the single-cycle mask write path.
- Sits between the vector execute/LSU writeback and operand fetch.

Parameters:
VLEN, 128, bits per vector register
NUM_REGS, 32, number of architectural vector registers (power of 2)
MAX_LMUL, 8, largest supported group size (1,2,4,8)
WR_REGS_PER_CYC, 1, registers committed per write beat (power of 2, <= MAX_LMUL)
ADDR_WIDTH, $clog2(NUM_REGS), derived register address width

Ports:
clk  in  1  single clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
raddr_1/raddr_2/raddr_3  in  ADDR_WIDTH  read group base addresses
rd_lmul  in  4  one-hot LMUL for all read ports
rdata_1/rdata_2/rdata_3  out  MAX_LMUL*VLEN  group read data, reg base in LSBs, zero above group
rd_err_1/rd_err_2/rd_err_3  out  1  read address illegal for rd_lmul (combinational)
rd_hazard_1/rd_hazard_2/rd_hazard_3  out  1  read group overlaps a pending write
wr_valid  in  1  write request valid
wr_ready  out  1  engine idle; request accepted when wr_valid & wr_ready
waddr  in  ADDR_WIDTH  write group base
wr_lmul  in  4  one-hot LMUL of write
wdata  in  MAX_LMUL*VLEN  write group data
mask_wr_en  in  1  write wdata[VLEN-1:0] into v0 this cycle
err_clr  in  1  clear sticky wrong_addr
busy  out  1  write engine in WRITE state
data_written  out  1  one-cycle pulse when a group write completes
wrong_addr  out  1  sticky illegal-write flag
v0_mask_data  out  VLEN  current contents of v0 (direct, combinational)

Behaviour:
- Reset (async, reset=0):
  - all registers 0; pending mask 0; state IDLE
  - wr_ready=1, busy=0, data_written=0, wrong_addr=0
  - reset mid-write abandons the write; no partial commit after reset deasserts
- Group legality, N = LMUL value:
  - lmul must be one-hot and N <= MAX_LMUL
  - base % N == 0 and base + N <= NUM_REGS
  - reads: illegal group gives rd_err_n=1 and rdata_n=0
  - reads return current array contents even when hazarded
- State machine IDLE/WRITE:
  - IDLE: wr_ready=1. On accept with a legal group: latch waddr, wr_lmul and wdata; set pending bits for all N registers; go to WRITE with beat=0.
  - IDLE, illegal group: the handshake completes, nothing is written, wrong_addr<=1 at the next edge, stay IDLE.
  - WRITE: wr_ready=0, busy=1. Each edge commits registers base+beat*W .. base+beat*W+W-1 and clears their pending bits.
  - WRITE, last beat (beat = N/W-1, or the only beat when N <= W): data_written=1 for one cycle, registered on the same edge as the final commit; return to IDLE.
  - Group latency: max(1, N/W) cycles from accept to completion; back-to-back accept is possible the cycle after data_written.
- v0 protection:
  - a group write covering v0 skips the v0 slice; its pending bit is never set
  - the remaining registers are written normally
- mask_wr_en:
  - writes v0 on the same edge, independent of engine state; no effect on busy or data_written
  - concurrent with a WRITE beat, both take effect
- wrong_addr stays 1 until err_clr=1. If err_clr and a new error occur on the same edge, the error wins.
- Hazards: rd_hazard_n = |(pending & group_mask(raddr_n, rd_lmul)); forced 0 when rd_err_n=1.
- Simultaneous commit and read of the same register: the read sees the old value and the hazard stays 1 until after the edge.

Test Plan:
- VLEN=128, W=1: accept waddr=8, wr_lmul=4'b0100, wdata words 0x1..0x4 -> wr_ready=0 for 4 cycles; v8..v11 = 1,2,3,4 committed one per edge; data_written pulses on the 4th edge; wr_ready=1 next cycle.
- During the above, raddr_1=10, rd_lmul=1 -> rd_hazard_1=1 until the 3rd commit edge; then 0 and rdata_1[127:0]=0x3.
- Accept waddr=0, wr_lmul=2, wdata all-ones, with v0 preloaded 0xA5 -> v0 stays 0xA5, v1=all-ones, data_written after 2 cycles.
- mask_wr_en=1, wdata[127:0]=0xF0F0 during beat 1 of an 8-reg write at v8 -> v0_mask_data=0xF0F0 next cycle; v8..v15 complete normally after 8 cycles.
- Accept waddr=6, wr_lmul=4 -> no register changes, wrong_addr=1 next edge and held; err_clr=1 -> wrong_addr=0 next edge.
- Assert reset during beat 2 of a waddr=16, lmul=8 write -> all registers 0, busy=0, wr_ready=1, all rd_hazard=0, data_written never pulses.
